motor_speed_timer_ctrl: RTL



---
 rtl/motor_pkg.sv | 18 +
 rtl/pwm_generator.sv | 46 ++++
 rtl/motor_speed_timer_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared speed encoding and default duty constants for the motor controller and display decoder.
package motor_pkg;

    localparam logic [1:0] SPEED_OFF  = 2'd0;
    localparam logic [1:0] SPEED_LOW  = 2'd1;
    localparam logic [1:0] SPEED_MID  = 2'd2;
    localparam logic [1:0] SPEED_HIGH = 2'd3;

    localparam int unsigned DEF_DUTY_LOW  = 3;
    localparam int unsigned DEF_DUTY_MID  = 6;
    localparam int unsigned DEF_DUTY_HIGH = 9;

    // OFF->LOW->MID->HIGH->OFF is a plain 2-bit increment with wrap.
    function automatic logic [1:0] next_speed(input logic [1:0] speed);
        return speed + 2'd1;
    endfunction

endpackage

// File: rtl/pwm_generator.sv
// Tick-driven PWM: period counter, duty latch updated at wrap or on demand, registered output.
module pwm_generator #(
    parameter int unsigned PWM_PERIOD = 10,
    parameter int unsigned DW         = $clog2(PWM_PERIOD + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_tick,
    input  logic          i_running,
    input  logic          i_load_now,
    input  logic          i_clear,
    input  logic [DW-1:0] i_duty,
    output logic          o_pwm
);

    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_duty;
    logic          r_pwm;
    logic          w_wrap;

    assign w_wrap = i_tick && (r_cnt == DW'(PWM_PERIOD - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_pwm <= i_running && (r_cnt < r_duty);
            if (i_load_now) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                r_cnt <= w_wrap ? '0 : r_cnt + DW'(1);
            end
            // Duty only changes at a period boundary so a running period is never truncated.
            if (i_clear) begin
                r_duty <= '0;
            end else if (i_load_now || w_wrap) begin
                r_duty <= i_duty;
            end
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/motor_speed_timer_ctrl.sv
// Fan/motor controller: speed FSM, auto-off countdown timer in seconds, and PWM drive.
module motor_speed_timer_ctrl
    import motor_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned PWM_PERIOD    = 10,
    parameter int unsigned DUTY_LOW      = DEF_DUTY_LOW,
    parameter int unsigned DUTY_MID      = DEF_DUTY_MID,
    parameter int unsigned DUTY_HIGH     = DEF_DUTY_HIGH,
    parameter int unsigned TIMER_STEP_S  = 30,
    parameter int unsigned TIMER_MAX_S   = 90
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_btn_speed,
    input  logic       i_btn_timer,
    input  logic       i_btn_stop,
    output logic       o_pwm,
    output logic [1:0] o_speed,
    output logic [6:0] o_timer_s,
    output logic       o_running
);

    localparam int unsigned DW = $clog2(PWM_PERIOD + 1);
    localparam int unsigned SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [1:0]    r_state;
    logic [6:0]    r_timer;
    logic [SW-1:0] r_sec;

    logic [1:0]    w_state_d;
    logic [6:0]    w_timer_d;
    logic [SW-1:0] w_sec_d;
    logic [7:0]    w_sum;
    logic          w_expire;
    logic          w_load_now;
    logic          w_clear;
    logic [DW-1:0] w_duty;

    function automatic logic [DW-1:0] duty_of(input logic [1:0] speed);
        logic [DW-1:0] duty;
        unique case (speed)
            SPEED_LOW:  duty = DW'(DUTY_LOW);
            SPEED_MID:  duty = DW'(DUTY_MID);
            SPEED_HIGH: duty = DW'(DUTY_HIGH);
            default:    duty = '0;
        endcase
        return duty;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= SPEED_OFF;
            r_timer <= '0;
            r_sec   <= '0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
            r_sec   <= w_sec_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer;
        w_sec_d   = r_sec;
        w_expire  = 1'b0;
        w_sum     = '0;
        if ((r_timer != 7'd0) && i_tick) begin
            if (r_sec == SW'(TICKS_PER_SEC - 1)) begin
                w_sec_d   = '0;
                w_timer_d = r_timer - 7'd1;
                w_expire  = (r_timer == 7'd1);
            end else begin
                w_sec_d = r_sec + SW'(1);
            end
        end
        if (i_btn_stop || w_expire) begin
            w_state_d = SPEED_OFF;
        end else begin
            if (i_btn_speed) begin
                w_state_d = next_speed(r_state);
            end
            // A step added mid-count keeps the second counter running.
            if (i_btn_timer && (r_state != SPEED_OFF) && (w_state_d != SPEED_OFF)) begin
                w_sum     = {1'b0, w_timer_d} + 8'(TIMER_STEP_S);
                w_timer_d = (w_sum > 8'(TIMER_MAX_S)) ? 7'd0 : w_sum[6:0];
            end
        end
        if (w_state_d == SPEED_OFF) begin
            w_timer_d = '0;
        end
        if (w_timer_d == 7'd0) begin
            w_sec_d = '0;
        end
    end

    always_comb begin
        w_load_now = (r_state == SPEED_OFF) && (w_state_d != SPEED_OFF);
        w_clear    = (w_state_d == SPEED_OFF);
        w_duty     = w_load_now ? duty_of(w_state_d) : duty_of(r_state);
        o_speed    = r_state;
        o_running  = (r_state != SPEED_OFF);
        o_timer_s  = r_timer;
    end

    pwm_generator #(
        .PWM_PERIOD(PWM_PERIOD),
        .DW        (DW)
    ) u_pwm (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_tick    (i_tick),
        .i_running (o_running),
        .i_load_now(w_load_now),
        .i_clear   (w_clear),
        .i_duty    (w_duty),
        .o_pwm     (o_pwm)
    );

endmodule
